// File: rtl/eviction_buffer.sv
// Write-back eviction buffer between the L2 pmem port and physical memory.
// Absorbs dirty-line writes, drains when idle, forwards read hits.
module eviction_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [ADDR_W-1:0]        mem_address,
  input  logic [LINE_W-1:0]        mem_wdata,
  output logic                     mem_resp,
  output logic [LINE_W-1:0]        mem_rdata,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic                     pmem_resp,
  input  logic [LINE_W-1:0]        pmem_rdata,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - 5;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    RD_MEM,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DEPTH-1:0]  ent_valid;
  logic [TAG_W-1:0]  ent_tag  [DEPTH];
  logic [LINE_W-1:0] ent_line [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  logic [TAG_W-1:0]  rd_tag;

  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic [PW-1:0]     hit_idx;
  logic              full;

  logic do_coal;
  logic do_push;
  logic do_rhit;
  logic do_rmem;
  logic do_pop;
  logic rd_start;

  logic unused_offset;

  assign req_tag       = mem_address[ADDR_W-1:5];
  assign unused_offset = ^mem_address[4:0];
  assign full          = (count == (PW+1)'(DEPTH));
  assign buf_count     = count;

  // Tag match of the request against every valid entry.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_tag[i] == req_tag) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // Next state, datapath strobes and memory-side outputs.
  always_comb begin
    state_nx     = state;
    do_coal      = 1'b0;
    do_push      = 1'b0;
    do_rhit      = 1'b0;
    do_rmem      = 1'b0;
    do_pop       = 1'b0;
    rd_start     = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state)
      IDLE: begin
        if (mem_write) begin
          if (hit) begin
            do_coal  = 1'b1;
            state_nx = RESP;
          end else if (!full) begin
            do_push  = 1'b1;
            state_nx = RESP;
          end else begin
            state_nx = DRAIN;
          end
        end else if (mem_read) begin
          if (hit) begin
            do_rhit  = 1'b1;
            state_nx = RESP;
          end else begin
            rd_start = 1'b1;
            state_nx = RD_MEM;
          end
        end else if (count != '0) begin
          state_nx = DRAIN;
        end
      end
      RESP: begin
        mem_resp = 1'b1;
        state_nx = IDLE;
      end
      RD_MEM: begin
        pmem_read    = 1'b1;
        pmem_address = {rd_tag, 5'b0};
        if (pmem_resp) begin
          do_rmem  = 1'b1;
          state_nx = RESP;
        end
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {ent_tag[head], 5'b0};
        pmem_wdata   = ent_line[head];
        if (pmem_resp) begin
          do_pop   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FIFO storage, pointers and read-data latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rd_tag    <= '0;
      mem_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_tag[i]  <= '0;
        ent_line[i] <= '0;
      end
    end else begin
      if (do_coal) begin
        ent_line[hit_idx] <= mem_wdata;
      end
      if (do_push) begin
        ent_valid[tail] <= 1'b1;
        ent_tag[tail]   <= req_tag;
        ent_line[tail]  <= mem_wdata;
        tail            <= tail + 1'b1;
        count           <= count + 1'b1;
      end
      if (do_rhit) begin
        mem_rdata <= ent_line[hit_idx];
      end
      if (rd_start) begin
        rd_tag <= req_tag;
      end
      if (do_rmem) begin
        mem_rdata <= pmem_rdata;
      end
      if (do_pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
        count           <= count - 1'b1;
      end
    end
  end

endmodule
